// File: rtl/tribus_arbiter.sv
// Round-robin arbiter that hands one tri-state bus to one of N requesters at a time.
// Grant is registered and follows req in the same edge; a high-Z turnaround separates owners.
module tribus_arbiter #(
  parameter int N           = 4,
  parameter int W           = 8,
  parameter int MAX_HOLD    = 16,
  parameter int TURN_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] din,
  output logic [N-1:0]   gnt,
  output logic           bus_oe,
  output tri   [W-1:0]   bus,
  output logic           busy
);

  localparam int PW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] turn_q, turn_d;
  logic [N-1:0]  gnt_q, gnt_d;

  logic          found;
  logic [PW-1:0] win;
  logic [PW-1:0] cand_idx;
  logic [PW-1:0] ptr_next;
  logic [W-1:0]  bus_dat;
  int            cand;

  // Scan from the highest offset down so the request closest to ptr is the last one kept.
  always_comb begin
    found    = 1'b0;
    win      = ptr_q;
    cand     = 0;
    cand_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr_q) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = PW'(cand);
      if (req[cand_idx]) begin
        found = 1'b1;
        win   = cand_idx;
      end
    end
  end

  assign ptr_next = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d    = win;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          hold_d     = HW'(1);
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!req[owner_q] || hold_q == HW'(MAX_HOLD)) begin
          gnt_d   = '0;
          ptr_d   = ptr_next;
          turn_d  = TW'(1);
          state_d = TURN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      TURN: begin
        if (turn_q == TW'(TURN_CYCLES)) state_d = IDLE;
        else                            turn_d  = turn_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus drive depends only on the registered grant, never on the next-state logic.
  always_comb begin
    busy    = (state_q != IDLE);
    bus_oe  = |gnt_q;
    bus_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) bus_dat = bus_dat | din[i*W +: W];
    end
  end

  assign gnt = gnt_q;
  assign bus = bus_oe ? bus_dat : {W{1'bz}};

endmodule
